// File: rtl/ltc2308_reader_if.sv
// User-side request/result bundle of the LTC2308 reader.
interface ltc2308_reader_if;
    logic        start_i;
    logic [2:0]  channel_i;
    logic        busy_o;
    logic        valid_o;
    logic [11:0] data_o;

    modport master (output start_i, channel_i, input busy_o, valid_o, data_o);
    modport slave  (input start_i, channel_i, output busy_o, valid_o, data_o);
endinterface

// File: rtl/ltc2308_reader.sv
// LTC2308 SAR ADC reader: CONVST pulse, then 12 SCK periods that send the
// 6-bit config word on SDI while capturing the 12-bit result from SDO.
module ltc2308_reader #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic            clk,
    input  logic            reset,
    ltc2308_reader_if.slave ctl,
    output logic            adc_convst_o,
    output logic            adc_sck_o,
    output logic            adc_sdi_o,
    input  logic            adc_sdo_i
);

    localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] conv_cnt;
    logic [DW-1:0] div_cnt;
    logic          sck_hi;
    logic [3:0]    bit_idx;
    logic [2:0]    ch_q;
    logic [10:0]   shreg;

    // SDI bit idx (0 = first on the wire): S/D, O/S, S1, S0, UNI, SLP, then zeros
    function automatic logic cfg_bit(input logic [2:0] ch, input logic [3:0] idx);
        logic [11:0] word;
        word = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0, 6'b000000};
        return word[4'd11 - idx];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            conv_cnt     <= '0;
            div_cnt      <= '0;
            sck_hi       <= 1'b0;
            bit_idx      <= '0;
            ch_q         <= '0;
            shreg        <= '0;
            ctl.busy_o   <= 1'b0;
            ctl.valid_o  <= 1'b0;
            ctl.data_o   <= '0;
            adc_convst_o <= 1'b0;
            adc_sck_o    <= 1'b0;
            adc_sdi_o    <= 1'b0;
        end else begin
            ctl.valid_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctl.start_i) begin
                        state        <= CONV;
                        ch_q         <= ctl.channel_i;
                        conv_cnt     <= '0;
                        adc_convst_o <= 1'b1;
                        ctl.busy_o   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    if (conv_cnt == CONV_LAST) begin
                        state        <= SHIFT;
                        adc_convst_o <= 1'b0;
                        adc_sdi_o    <= cfg_bit(ch_q, 4'd0);
                        div_cnt      <= '0;
                        sck_hi       <= 1'b0;
                        bit_idx      <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (!sck_hi) begin
                        div_cnt   <= '0;
                        adc_sck_o <= 1'b1;
                        sck_hi    <= 1'b1;
                    end else begin
                        // End of high phase: SCK falls and SDO is captured here
                        div_cnt   <= '0;
                        adc_sck_o <= 1'b0;
                        sck_hi    <= 1'b0;
                        shreg     <= {shreg[9:0], adc_sdo_i};
                        if (bit_idx == 4'd11) begin
                            state       <= DONE;
                            ctl.valid_o <= 1'b1;
                            ctl.data_o  <= {shreg, adc_sdo_i};
                            ctl.busy_o  <= 1'b0;
                            adc_sdi_o   <= 1'b0;
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            adc_sdi_o <= cfg_bit(ch_q, bit_idx + 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_reader.sv
// Randomized bench for ltc2308_reader against a bus-level LTC2308 model.
module tb_ltc2308_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ltc2308_reader_if bus0();
    ltc2308_reader_if bus1();
    logic convst0, sck0, sdi0, sdo0;
    logic convst1, sck1, sdi1, sdo1;

    ltc2308_reader dut0 (
        .clk(clk), .reset(reset), .ctl(bus0),
        .adc_convst_o(convst0), .adc_sck_o(sck0), .adc_sdi_o(sdi0), .adc_sdo_i(sdo0)
    );

    ltc2308_reader #(.CLK_DIV(1), .CONV_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .ctl(bus1),
        .adc_convst_o(convst1), .adc_sck_o(sck1), .adc_sdi_o(sdi1), .adc_sdo_i(sdo1)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Config words from the LTC2308 single-ended/unipolar table, padded with six zeros
    logic [5:0] cfg_tbl [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                6'b101010, 6'b111010, 6'b101110, 6'b111110};

    // ADC models: result word latched at CONVST rise, MSB out first, next bit after each SCK fall
    logic [11:0] next_word0 = '0, cur_word0 = '0, sdi_cap0 = '0;
    logic [11:0] next_word1 = '0, cur_word1 = '0, sdi_cap1 = '0;
    int nfall0 = 0, rises0 = 0, nfall1 = 0, rises1 = 0;
    initial begin sdo0 = 1'b0; sdo1 = 1'b0; end

    always @(posedge convst0 or posedge sck0 or negedge sck0) begin
        if (convst0) begin
            cur_word0 = next_word0; nfall0 = 0; rises0 = 0; sdi_cap0 = '0;
            sdo0 = next_word0[11];
        end else if (sck0) begin
            rises0++; sdi_cap0 = {sdi_cap0[10:0], sdi0};
        end else begin
            nfall0++; sdo0 = (nfall0 < 12) ? cur_word0[11 - nfall0] : 1'b0;
        end
    end

    always @(posedge convst1 or posedge sck1 or negedge sck1) begin
        if (convst1) begin
            cur_word1 = next_word1; nfall1 = 0; rises1 = 0; sdi_cap1 = '0;
            sdo1 = next_word1[11];
        end else if (sck1) begin
            rises1++; sdi_cap1 = {sdi_cap1[10:0], sdi1};
        end else begin
            nfall1++; sdo1 = (nfall1 < 12) ? cur_word1[11 - nfall1] : 1'b0;
        end
    end

    int vcount0 = 0;
    always @(posedge clk) if (bus0.valid_o) vcount0++;

    logic [11:0] last_data0 = '0;

    // Called at a negedge; the DUT accepts on the following posedge. Returns at the valid cycle.
    task automatic txn0(input logic [11:0] word, input logic [2:0] ch, input bit hold, input bit extra);
        int cyc, conv_hi;
        bit seen, busy_ok, held_ok;
        next_word0 = word;
        bus0.start_i = 1'b1;
        bus0.channel_i = ch;
        cyc = 0; conv_hi = 0; seen = 0; busy_ok = 1; held_ok = 1;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold) bus0.start_i = extra && (cyc == 10 || cyc == 100);
            bus0.channel_i = 3'($urandom);
            if (bus0.valid_o) begin
                seen = 1;
            end else begin
                busy_ok &= (bus0.busy_o == 1'b1);
                held_ok &= (bus0.data_o == last_data0);
                conv_hi += int'(convst0);
            end
        end
        if (!hold) bus0.start_i = 1'b0;
        check("latency", cyc, 129);
        check("data", bus0.data_o, word);
        check("busy_in_flight", busy_ok, 1);
        check("busy_at_done", bus0.busy_o, 0);
        check("data_held", held_ok, 1);
        check("convst_cycles", conv_hi, 80);
        check("convst_low_done", convst0, 0);
        check("sck_rises", rises0, 12);
        check("sdi_word", sdi_cap0, {cfg_tbl[ch], 6'b000000});
        last_data0 = word;
    endtask

    task automatic txn1(input logic [11:0] word, input logic [2:0] ch);
        int cyc;
        bit seen;
        next_word1 = word;
        bus1.start_i = 1'b1;
        bus1.channel_i = ch;
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus1.start_i = 1'b0;
            if (bus1.valid_o) seen = 1;
        end
        check("fast_latency", cyc, 29);
        check("fast_data", bus1.data_o, word);
        check("fast_sck_rises", rises1, 12);
        check("fast_sdi_word", sdi_cap1, {cfg_tbl[ch], 6'b000000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vsave;
        bus0.start_i = 1'b0; bus0.channel_i = '0;
        bus1.start_i = 1'b0; bus1.channel_i = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus0.busy_o, 0);
        check("rst_valid", bus0.valid_o, 0);
        check("rst_data", bus0.data_o, 0);
        check("rst_convst", convst0, 0);
        check("rst_sck", sck0, 0);
        check("rst_sdi", sdi0, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single conversion on channel 5, extra starts ignored while busy
        vsave = vcount0;
        txn0(12'hA5C, 3'd5, 1'b0, 1'b1);
        repeat (150) @(negedge clk);
        check("one_valid", vcount0 - vsave, 1);
        check("idle_busy", bus0.busy_o, 0);

        // Reset mid-SHIFT aborts the transaction
        vsave = vcount0;
        bus0.start_i = 1'b1; bus0.channel_i = 3'd2; next_word0 = 12'h3C3;
        @(negedge clk);
        bus0.start_i = 1'b0;
        repeat (99) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", bus0.busy_o, 0);
        check("abort_valid", bus0.valid_o, 0);
        check("abort_data", bus0.data_o, 0);
        check("abort_convst", convst0, 0);
        check("abort_sck", sck0, 0);
        check("abort_sdi", sdi0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_valid", vcount0 - vsave, 0);
        last_data0 = '0;
        txn0(12'h5A3, 3'd1, 1'b0, 1'b0);

        // Back-to-back with start held high
        txn0(12'h000, 3'd3, 1'b1, 1'b0);
        txn0(12'hFFF, 3'd4, 1'b1, 1'b0);
        bus0.start_i = 1'b0;
        repeat (5) @(negedge clk);

        // Every channel's config word
        for (int c = 0; c < 8; c++) txn0(12'($urandom), 3'(c), 1'b0, 1'b0);

        // Random mix of isolated and back-to-back transactions
        for (int k = 0; k < 6; k++) begin
            txn0(12'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end
        bus0.start_i = 1'b0;
        repeat (3) @(negedge clk);

        // Short divider / conversion time instance
        txn1(12'($urandom), 3'd6);
        repeat (3) @(negedge clk);
        txn1(12'($urandom), 3'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
